// File: rtl/mdu_divider_seq.sv
// Iterative radix-2 restoring divider for the execute-stage MDU.
// Produces {remainder, quotient} after WIDTH+2 edges; done is high whenever idle.
module mdu_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           div_op,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic               signedMode_q;
  logic               dividendNeg_q;
  logic               signDiff_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   divisorMag_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] result_q;
  logic               done_q;

  logic               accept;
  logic               isSigned;
  logic [WIDTH-1:0]   dividendMag_d;
  logic [WIDTH-1:0]   divisorMag_d;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   quotFix_d;
  logic [WIDTH-1:0]   remFix_d;

  // The trial difference is WIDTH+1 bits wide so that its top bit is a true sign,
  // even for the 2^(WIDTH-1) magnitude and for full-range unsigned divisors.
  always_comb begin
    accept        = 1'b0;
    isSigned      = 1'b0;
    dividendMag_d = dividend;
    divisorMag_d  = divisor;
    shifted       = {rem_q, quot_q[WIDTH-1]};
    trial         = shifted - {1'b0, divisorMag_q};
    rem_d         = shifted[WIDTH-1:0];
    quot_d        = {quot_q[WIDTH-2:0], 1'b0};
    quotFix_d     = quot_q;
    remFix_d      = rem_q;

    accept   = (state_q == IDLE) && ((div_op == 2'b10) || (div_op == 2'b01));
    isSigned = (div_op == 2'b10);
    if (isSigned && dividend[WIDTH-1]) dividendMag_d = -dividend;
    if (isSigned && divisor[WIDTH-1])  divisorMag_d  = -divisor;

    if (!trial[WIDTH]) begin
      rem_d  = trial[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b1};
    end

    if (signedMode_q && signDiff_q)    quotFix_d = -quot_q;
    if (signedMode_q && dividendNeg_q) remFix_d  = -rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      signedMode_q  <= 1'b0;
      dividendNeg_q <= 1'b0;
      signDiff_q    <= 1'b0;
      rem_q         <= '0;
      quot_q        <= '0;
      divisorMag_q  <= '0;
      count_q       <= '0;
      result_q      <= '0;
      done_q        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            signedMode_q  <= isSigned;
            dividendNeg_q <= isSigned & dividend[WIDTH-1];
            signDiff_q    <= isSigned & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            quot_q        <= dividendMag_d;
            divisorMag_q  <= divisorMag_d;
            rem_q         <= '0;
            count_q       <= '0;
            done_q        <= 1'b0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          rem_q   <= rem_d;
          quot_q  <= quot_d;
          count_q <= count_q + CNT_ONE;
          if (count_q == CNT_LAST) state_q <= FIX;
        end
        FIX: begin
          result_q <= {remFix_d, quotFix_d};
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
